// File: rtl/krnl_acc_ctrl_pkg.sv
// Shared definitions for the accelerator control-register master.
// - Register map of the control slave (12-bit AXI4-Lite byte addresses).
// - CTRL bit positions and the masks derived from them.
// - Job descriptor struct, job status and FSM state encodings.
// - Helpers that give the address and data of the n-th write in a job.
package krnl_acc_ctrl_pkg;

  localparam logic [11:0] ADDR_CTRL   = 12'h000;
  localparam logic [11:0] ADDR_CFG_CI = 12'h010;
  localparam logic [11:0] ADDR_CFG_CO = 12'h018;
  localparam logic [11:0] ADDR_IFM_LO = 12'h020;
  localparam logic [11:0] ADDR_IFM_HI = 12'h024;
  localparam logic [11:0] ADDR_WGT_LO = 12'h028;
  localparam logic [11:0] ADDR_WGT_HI = 12'h02C;
  localparam logic [11:0] ADDR_OFM_LO = 12'h030;
  localparam logic [11:0] ADDR_OFM_HI = 12'h034;

  localparam int CTRL_START = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_IDLE  = 2;
  localparam int CTRL_READY = 3;
  localparam int CTRL_CONT  = 4;

  localparam logic [31:0] CTRL_START_MASK = 32'h1 << CTRL_START;
  localparam logic [31:0] CTRL_DONE_MASK  = 32'h1 << CTRL_DONE;
  localparam logic [31:0] CTRL_CONT_MASK  = 32'h1 << CTRL_CONT;

  // Index of the ap_start write; writes 0..LAST_WR form the programming sequence.
  localparam logic [3:0] LAST_WR = 4'd8;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_BUS_ERR = 2'd1,
    ST_TIMEOUT = 2'd2
  } status_e;

  typedef enum logic [3:0] {
    IDLE, WR_REQ, WR_RESP, POLL_GAP_ST, RD_REQ, RD_RESP, CONT_REQ, CONT_RESP, FIN
  } state_e;

  typedef struct packed {
    logic [31:0] ci;
    logic [31:0] co;
    logic [63:0] ifm;
    logic [63:0] wgt;
    logic [63:0] ofm;
  } job_desc_t;

  function automatic logic [11:0] wr_seq_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    return ADDR_CFG_CI;
      4'd1:    return ADDR_CFG_CO;
      4'd2:    return ADDR_IFM_LO;
      4'd3:    return ADDR_IFM_HI;
      4'd4:    return ADDR_WGT_LO;
      4'd5:    return ADDR_WGT_HI;
      4'd6:    return ADDR_OFM_LO;
      4'd7:    return ADDR_OFM_HI;
      default: return ADDR_CTRL;
    endcase
  endfunction

  function automatic logic [31:0] wr_seq_data(input job_desc_t d, input logic [3:0] idx);
    case (idx)
      4'd0:    return d.ci;
      4'd1:    return d.co;
      4'd2:    return d.ifm[31:0];
      4'd3:    return d.ifm[63:32];
      4'd4:    return d.wgt[31:0];
      4'd5:    return d.wgt[63:32];
      4'd6:    return d.ofm[31:0];
      4'd7:    return d.ofm[63:32];
      default: return CTRL_START_MASK;
    endcase
  endfunction

endpackage

// File: rtl/krnl_acc_axil_wr_txn.sv
// Single AXI4-Lite write engine.
// While req is held high, AWVALID and WVALID are raised together and each is
// dropped independently after its own handshake; once both have completed,
// BREADY is raised until the B handshake. Deasserting req (or reset) abandons
// the transaction. addr/data must be held stable by the caller while req=1.
// Ports:
//   ACLK, ARESET      clock, synchronous active-high reset
//   req, addr, data   write request (level) with its address and data
//   AW*/W*/B*         AXI4-Lite write channels
//   addr_data_fin     AW and W both complete by the end of this cycle
//   ack               B handshake this cycle (transaction finished)
//   err               ack with a non-OKAY BRESP
import krnl_acc_ctrl_pkg::*;

module krnl_acc_axil_wr_txn (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        req,
  input  logic [11:0] addr,
  input  logic [31:0] data,
  output logic [11:0] AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY,
  output logic        addr_data_fin,
  output logic        ack,
  output logic        err
);

  logic aw_done, w_done;
  logic aw_hs, w_hs;

  assign AWADDR  = addr;
  assign WDATA   = data;
  assign WSTRB   = 4'hF;
  assign AWVALID = req & ~aw_done;
  assign WVALID  = req & ~w_done;
  assign BREADY  = req & aw_done & w_done;

  assign aw_hs         = AWVALID & AWREADY;
  assign w_hs          = WVALID & WREADY;
  assign addr_data_fin = (aw_done | aw_hs) & (w_done | w_hs);
  assign ack           = BREADY & BVALID;
  assign err           = ack & (BRESP != 2'b00);

  // Completion flags clear on the B handshake so a back-to-back request
  // raises its VALIDs only in the cycle after that handshake.
  always_ff @(posedge ACLK) begin
    if (ARESET || !req || ack) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

endmodule

// File: rtl/krnl_acc_axi_ctrl_master.sv
// AXI4-Lite control master for the accelerator.
// Accepts one job descriptor, programs CFG_CI/CFG_CO and the IFM/WGT/OFM base
// addresses, writes ap_start, polls CTRL every POLL_GAP idle cycles until
// ap_done (or MAX_POLLS reads), writes ap_continue and pulses done with status.
// Ports:
//   ACLK, ARESET            clock, synchronous active-high reset
//   cmd_valid/cmd_ready     descriptor handshake (ready only in IDLE)
//   cmd_ci, cmd_co          channel config values
//   cmd_ifm/wgt/ofm         64-bit base addresses
//   busy, done, status      job in progress, completion pulse, result code
//   AW*/W*/B*/AR*/R*        AXI4-Lite master channels
import krnl_acc_ctrl_pkg::*;

module krnl_acc_axi_ctrl_master #(
  parameter int POLL_GAP  = 16,
  parameter int MAX_POLLS = 65535,
  parameter int CNT_W     = 16
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_ci,
  input  logic [31:0] cmd_co,
  input  logic [63:0] cmd_ifm,
  input  logic [63:0] cmd_wgt,
  input  logic [63:0] cmd_ofm,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [11:0] AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY,
  output logic [11:0] ARADDR,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY
);

  localparam logic [CNT_W-1:0] POLL_LIMIT = CNT_W'(MAX_POLLS);
  localparam logic [CNT_W-1:0] GAP_LAST   = (POLL_GAP > 0) ? CNT_W'(POLL_GAP - 1) : '0;
  // With no gap the poll loop goes straight back to the read request.
  localparam state_e GAP_ENTRY = (POLL_GAP == 0) ? RD_REQ : POLL_GAP_ST;

  state_e           state_q, state_d;
  job_desc_t        desc_q, desc_d;
  logic [3:0]       idx_q, idx_d;
  logic [11:0]      awaddr_q, awaddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       status_q, status_d;
  logic [CNT_W-1:0] poll_q, poll_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [3:0]       idx_inc;

  logic wr_req, wr_fin, wr_ack, wr_err;
  logic rd_done;

  assign rd_done   = |(RDATA & CTRL_DONE_MASK);
  assign idx_inc   = idx_q + 4'd1;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign status    = status_q;
  assign ARADDR    = ADDR_CTRL;

  krnl_acc_axil_wr_txn u_wr (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .req           (wr_req),
    .addr          (awaddr_q),
    .data          (wdata_q),
    .AWADDR        (AWADDR),
    .AWVALID       (AWVALID),
    .AWREADY       (AWREADY),
    .WDATA         (WDATA),
    .WSTRB         (WSTRB),
    .WVALID        (WVALID),
    .WREADY        (WREADY),
    .BRESP         (BRESP),
    .BVALID        (BVALID),
    .BREADY        (BREADY),
    .addr_data_fin (wr_fin),
    .ack           (wr_ack),
    .err           (wr_err)
  );

  always_comb begin
    state_d  = state_q;
    desc_d   = desc_q;
    idx_d    = idx_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    status_d = status_q;
    poll_d   = poll_q;
    gap_d    = gap_q;
    wr_req   = 1'b0;
    ARVALID  = 1'b0;
    RREADY   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          desc_d   = '{ci: cmd_ci, co: cmd_co, ifm: cmd_ifm, wgt: cmd_wgt, ofm: cmd_ofm};
          idx_d    = '0;
          awaddr_d = ADDR_CFG_CI;
          wdata_d  = cmd_ci;
          status_d = ST_OK;
          poll_d   = '0;
          state_d  = WR_REQ;
        end
      end
      WR_REQ: begin
        wr_req = 1'b1;
        if (wr_fin) state_d = WR_RESP;
      end
      WR_RESP: begin
        wr_req = 1'b1;
        if (wr_ack) begin
          if (wr_err) begin
            status_d = ST_BUS_ERR;
            state_d  = FIN;
          end else if (idx_q == LAST_WR) begin
            gap_d   = '0;
            state_d = GAP_ENTRY;
          end else begin
            idx_d    = idx_inc;
            awaddr_d = wr_seq_addr(idx_inc);
            wdata_d  = wr_seq_data(desc_q, idx_inc);
            state_d  = WR_REQ;
          end
        end
      end
      POLL_GAP_ST: begin
        if (gap_q >= GAP_LAST) state_d = RD_REQ;
        else                   gap_d   = gap_q + 1'b1;
      end
      RD_REQ: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = RD_RESP;
      end
      RD_RESP: begin
        RREADY = 1'b1;
        if (RVALID) begin
          // Bus error is checked first so it wins over a same-cycle timeout.
          if (RRESP != 2'b00) begin
            status_d = ST_BUS_ERR;
            state_d  = FIN;
          end else if (rd_done) begin
            awaddr_d = ADDR_CTRL;
            wdata_d  = CTRL_CONT_MASK;
            state_d  = CONT_REQ;
          end else begin
            poll_d = (poll_q == {CNT_W{1'b1}}) ? poll_q : poll_q + 1'b1;
            if (poll_d >= POLL_LIMIT) begin
              status_d = ST_TIMEOUT;
              state_d  = FIN;
            end else begin
              gap_d   = '0;
              state_d = GAP_ENTRY;
            end
          end
        end
      end
      CONT_REQ: begin
        wr_req = 1'b1;
        if (wr_fin) state_d = CONT_RESP;
      end
      CONT_RESP: begin
        wr_req = 1'b1;
        if (wr_ack) begin
          if (wr_err) status_d = ST_BUS_ERR;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= IDLE;
      desc_q   <= '0;
      idx_q    <= '0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      status_q <= ST_OK;
      poll_q   <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      desc_q   <= desc_d;
      idx_q    <= idx_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      status_q <= status_d;
      poll_q   <= poll_d;
      gap_q    <= gap_d;
    end
  end

endmodule

// File: tb/tb_krnl_acc_axi_ctrl_master.sv
// Directed bench for krnl_acc_axi_ctrl_master with a reactive AXI4-Lite slave
// model (configurable AW/W ready delays, BRESP error address, done-after-N).
module tb_krnl_acc_axi_ctrl_master;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_ci = '0, cmd_co = '0;
  logic [63:0] cmd_ifm = '0, cmd_wgt = '0, cmd_ofm = '0;
  logic        busy, done;
  logic [1:0]  status;
  logic [11:0] AWADDR, ARADDR;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
  logic [1:0]  BRESP = '0, RRESP = '0;
  logic [31:0] RDATA = '0;

  always #5 ACLK = ~ACLK;

  krnl_acc_axi_ctrl_master #(.POLL_GAP(2), .MAX_POLLS(5), .CNT_W(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ci(cmd_ci), .cmd_co(cmd_co), .cmd_ifm(cmd_ifm), .cmd_wgt(cmd_wgt), .cmd_ofm(cmd_ofm),
    .busy(busy), .done(done), .status(status),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  // slave configuration
  int          aw_dly = 0, w_dly = 0, done_after = 0;
  logic [11:0] berr_addr = 12'hFFF;

  // slave / monitor state
  int          aw_cnt = 0, w_cnt = 0, rd_cnt = 0, cyc = 0;
  bit          aw_got, w_got, b_pend, r_pend, b_err;
  logic [11:0] cur_a;
  logic [31:0] cur_d;
  logic [43:0] wlog[$], exp_q[$];
  int          b_cyc[$], ar_cyc[$], r_cyc[$];
  int          aw_hs_n, done_n, stab_viol, drop_viol, bready_viol, busy_viol;
  logic [1:0]  done_st;
  bit          aw_hs_p, w_hs_p, aw_wait_p, w_wait_p, done_p;
  logic [11:0] awaddr_p;
  logic [31:0] wdata_p;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor: observes handshakes at the active edge.
  always @(posedge ACLK) begin
    cyc++;
    if (ARESET) begin
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      aw_hs_p = 0; w_hs_p = 0; aw_wait_p = 0; w_wait_p = 0; done_p = 0;
    end else begin
      if (aw_wait_p && (!AWVALID || AWADDR != awaddr_p)) stab_viol++;
      if (w_wait_p && (!WVALID || WDATA != wdata_p)) stab_viol++;
      if (aw_hs_p && AWVALID) drop_viol++;
      if (w_hs_p && WVALID) drop_viol++;
      if (BREADY && !b_pend) bready_viol++;
      if (BVALID && BREADY) begin b_pend = 0; b_cyc.push_back(cyc); end
      if (AWVALID && AWREADY) begin aw_got = 1; cur_a = AWADDR; aw_hs_n++; end
      if (WVALID && WREADY) begin w_got = 1; cur_d = WDATA; end
      if (aw_got && w_got) begin
        wlog.push_back({cur_a, cur_d});
        b_pend = 1; b_err = (cur_a == berr_addr); aw_got = 0; w_got = 0;
      end
      if (RVALID && RREADY) begin r_pend = 0; r_cyc.push_back(cyc); end
      if (ARVALID && ARREADY) begin r_pend = 1; rd_cnt++; ar_cyc.push_back(cyc); end
      if (done) begin
        done_n++; done_st = status;
        if (!busy || done_p) busy_viol++;
      end else if (done_p && busy) busy_viol++;
      aw_hs_p = AWVALID && AWREADY; w_hs_p = WVALID && WREADY;
      aw_wait_p = AWVALID && !AWREADY; w_wait_p = WVALID && !WREADY;
      awaddr_p = AWADDR; wdata_p = WDATA; done_p = done;
    end
  end

  // Slave drive, away from the active edge.
  always @(negedge ACLK) begin
    if (AWVALID) begin AWREADY = (aw_cnt >= aw_dly); aw_cnt++; end
    else begin AWREADY = 0; aw_cnt = 0; end
    if (WVALID) begin WREADY = (w_cnt >= w_dly); w_cnt++; end
    else begin WREADY = 0; w_cnt = 0; end
    BVALID = b_pend;
    BRESP  = (b_pend && b_err) ? 2'b10 : 2'b00;
    ARREADY = ARVALID;
    RVALID = r_pend;
    RDATA  = (r_pend && done_after != 0 && rd_cnt >= done_after) ? 32'h2 : 32'h0;
  end

  task automatic clear_mon();
    wlog.delete(); b_cyc.delete(); ar_cyc.delete(); r_cyc.delete();
    aw_hs_n = 0; done_n = 0; rd_cnt = 0;
    stab_viol = 0; drop_viol = 0; bready_viol = 0; busy_viol = 0;
  endtask

  task automatic start_job(input logic [31:0] ci, co, input logic [63:0] ifm, wgt, ofm);
    cmd_ci = ci; cmd_co = co; cmd_ifm = ifm; cmd_wgt = wgt; cmd_ofm = ofm;
    cmd_valid = 1;
    @(posedge ACLK); #1;
    cmd_valid = 0;
    chk("busy_rise", 64'(busy), 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && done_n == 0; i++) begin @(posedge ACLK); #1; end
    repeat (3) begin @(posedge ACLK); #1; end
  endtask

  task automatic build_exp(input logic [31:0] ci, co, input logic [63:0] ifm, wgt, ofm,
                           input int n_cfg, input bit cont);
    logic [43:0] all [9];
    all[0] = {12'h010, ci};          all[1] = {12'h018, co};
    all[2] = {12'h020, ifm[31:0]};   all[3] = {12'h024, ifm[63:32]};
    all[4] = {12'h028, wgt[31:0]};   all[5] = {12'h02C, wgt[63:32]};
    all[6] = {12'h030, ofm[31:0]};   all[7] = {12'h034, ofm[63:32]};
    all[8] = {12'h000, 32'h1};
    exp_q.delete();
    for (int i = 0; i < n_cfg; i++) exp_q.push_back(all[i]);
    if (cont) exp_q.push_back({12'h000, 32'h10});
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_nwr"}, 64'(wlog.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 64'(wlog[i]), 64'(exp_q[i]));
  endtask

  task automatic chk_viol(input string tag);
    chk({tag, "_stable"}, 64'(stab_viol), 0);
    chk({tag, "_vdrop"}, 64'(drop_viol), 0);
    chk({tag, "_bready"}, 64'(bready_viol), 0);
    chk({tag, "_busy_done"}, 64'(busy_viol), 0);
  endtask

  initial begin
    ARESET = 1;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_valids", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 0);
    chk("rst_flags", 64'({busy, done, status}), 0);
    chk("rst_cmd_ready", 64'(cmd_ready), 1);
    chk("rst_addr", 64'({AWADDR, ARADDR}), 0);
    chk("rst_wdata", 64'(WDATA), 0);
    chk("rst_wstrb", 64'(WSTRB), 64'hF);
    ARESET = 0;
    @(posedge ACLK); #1;

    // 1: nominal job, done on 3rd poll
    clear_mon(); done_after = 3;
    start_job(32'd3, 32'd8, 64'h1_0000_0000, 64'h2000, 64'h3000);
    wait_done();
    build_exp(32'd3, 32'd8, 64'h1_0000_0000, 64'h2000, 64'h3000, 9, 1);
    chk_log("t1");
    chk("t1_done_n", 64'(done_n), 1);
    chk("t1_status", 64'(done_st), 0);
    chk("t1_reads", 64'(rd_cnt), 3);
    chk("t1_nb", 64'(b_cyc.size()), 10);
    if (ar_cyc.size() == 3 && r_cyc.size() == 3 && b_cyc.size() >= 9) begin
      chk("t1_gap0", 64'(ar_cyc[0] - b_cyc[8]), 3);
      chk("t1_gap1", 64'(ar_cyc[1] - r_cyc[0]), 3);
      chk("t1_gap2", 64'(ar_cyc[2] - r_cyc[1]), 3);
    end
    chk("t1_idle_after", 64'({busy, cmd_ready}), 64'b01);
    chk_viol("t1");

    // 2: AW late vs W, then W late vs AW
    for (int k = 0; k < 2; k++) begin
      clear_mon(); done_after = 1;
      aw_dly = (k == 0) ? 4 : 0; w_dly = (k == 0) ? 0 : 4;
      start_job(32'hA5A5_0001, 32'h40, 64'hDEAD_BEEF_0000_1000, 64'h1_2345_6780, 64'hCAFE_0000_0000_8000);
      wait_done();
      build_exp(32'hA5A5_0001, 32'h40, 64'hDEAD_BEEF_0000_1000, 64'h1_2345_6780, 64'hCAFE_0000_0000_8000, 9, 1);
      chk_log($sformatf("t2_%0d", k));
      chk($sformatf("t2_%0d_nb", k), 64'(b_cyc.size()), 10);
      chk($sformatf("t2_%0d_status", k), 64'({done_n[1:0], done_st}), 64'b0100);
      chk_viol($sformatf("t2_%0d", k));
    end
    aw_dly = 0; w_dly = 0;

    // 3: BRESP error on CFG_CO write
    clear_mon(); done_after = 1; berr_addr = 12'h018;
    start_job(32'd5, 32'd6, 64'h10, 64'h20, 64'h30);
    wait_done();
    berr_addr = 12'hFFF;
    build_exp(32'd5, 32'd6, 64'h10, 64'h20, 64'h30, 2, 0);
    chk_log("t3");
    chk("t3_naw", 64'(aw_hs_n), 2);
    chk("t3_done_n", 64'(done_n), 1);
    chk("t3_status", 64'(done_st), 1);
    chk("t3_reads", 64'(rd_cnt), 0);

    // 4: slave never done -> timeout after 5 polls
    clear_mon(); done_after = 0;
    start_job(32'd1, 32'd2, 64'h100, 64'h200, 64'h300);
    wait_done();
    build_exp(32'd1, 32'd2, 64'h100, 64'h200, 64'h300, 9, 0);
    chk_log("t4");
    chk("t4_reads", 64'(rd_cnt), 5);
    chk("t4_done_n", 64'(done_n), 1);
    chk("t4_status", 64'(done_st), 2);
    chk_viol("t4");

    // 5: reset while WVALID is pending, then a clean job
    clear_mon(); w_dly = 20;
    start_job(32'd9, 32'd9, 64'h9, 64'h9, 64'h9);
    repeat (2) begin @(posedge ACLK); #1; end
    chk("t5_pre_wvalid", 64'({WVALID, WREADY}), 64'b10);
    ARESET = 1;
    @(posedge ACLK); #1;
    chk("t5_rst_valids", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 0);
    chk("t5_rst_ready", 64'({cmd_ready, busy}), 64'b10);
    ARESET = 0;
    repeat (10) begin @(posedge ACLK); #1; end
    chk("t5_no_done", 64'(done_n), 0);
    clear_mon(); w_dly = 0; done_after = 2;
    start_job(32'h11, 32'h22, 64'h3333_0000_4444, 64'h5555, 64'h6666_0000_0000);
    wait_done();
    build_exp(32'h11, 32'h22, 64'h3333_0000_4444, 64'h5555, 64'h6666_0000_0000, 9, 1);
    chk_log("t5");
    chk("t5_status", 64'({done_n[1:0], done_st}), 64'b0100);

    // 6: cmd toggled with new values while busy
    clear_mon(); done_after = 1;
    start_job(32'h77, 32'h88, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111, 64'h2222);
    for (int i = 0; i < 8; i++) begin
      cmd_valid = ~cmd_valid;
      cmd_ci = cmd_ci + 32'd100; cmd_co = cmd_co + 32'd100;
      cmd_ifm = cmd_ifm + 64'd7; cmd_wgt = cmd_wgt + 64'd7; cmd_ofm = cmd_ofm + 64'd7;
      @(posedge ACLK); #1;
    end
    cmd_valid = 0;
    wait_done();
    repeat (10) begin @(posedge ACLK); #1; end
    build_exp(32'h77, 32'h88, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111, 64'h2222, 9, 1);
    chk_log("t6");
    chk("t6_done_n", 64'(done_n), 1);
    chk("t6_status", 64'(done_st), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/krnl_acc_axi_ctrl_master.md
Name: krnl_acc_axi_ctrl_master

Overview:
AXI4-Lite initiator that drives the accelerator's control-register slave. It takes one job descriptor (channel config plus IFM/WGT/OFM base addresses) and programs the slave's register file. It then sets ap_start, polls CTRL until ap_done, pulses ap_continue and reports completion. It is used by the on-chip sequencer and by the system testbench in place of host software.

Parameters:
- POLL_GAP, 16: idle cycles between consecutive CTRL reads (0 means back-to-back polling).
- MAX_POLLS, 65535: CTRL reads allowed before a timeout is declared.
- CNT_W, 16: width of the poll and gap counters; must satisfy 2^CNT_W > max(POLL_GAP, MAX_POLLS).

Ports:
- ACLK in 1: clock.
- ARESET in 1: reset, synchronous, active-high; sampled on the ACLK rising edge.
- cmd_valid in 1: job descriptor valid.
- cmd_ready out 1: high only in IDLE.
- cmd_ci in 32: value for CFG_CI.
- cmd_co in 32: value for CFG_CO.
- cmd_ifm in 64: IFM base address.
- cmd_wgt in 64: WGT base address.
- cmd_ofm in 64: OFM base address.
- busy out 1: job in progress.
- done out 1: one-cycle completion pulse.
- status out 2: job result, valid with done: 0 OK, 1 bus error, 2 timeout.
- AWADDR out 12, AWVALID out 1, AWREADY in 1: write address channel.
- WDATA out 32, WSTRB out 4, WVALID out 1, WREADY in 1: write data channel.
- BRESP in 2, BVALID in 1, BREADY out 1: write response channel.
- ARADDR out 12, ARVALID out 1, ARREADY in 1: read address channel.
- RDATA in 32, RRESP in 2, RVALID in 1, RREADY out 1: read data channel.

Behaviour:
- Reset values: every VALID/READY output 0; busy 0, done 0, status 0; AWADDR, ARADDR and WDATA 0; WSTRB 4'hF constant; state IDLE.
- A descriptor is accepted on cmd_valid&cmd_ready. It is latched whole into internal registers, and cmd inputs are ignored while busy. busy rises the next cycle.
- Write sequence, fixed order:
  - 0x010 = ci
  - 0x018 = co
  - 0x020 = ifm[31:0], 0x024 = ifm[63:32]
  - 0x028 = wgt[31:0], 0x02C = wgt[63:32]
  - 0x030 = ofm[31:0], 0x034 = ofm[63:32]
  - 0x000 = 0x0000_0001 (ap_start)
- Write transaction:
  - AWVALID and WVALID assert together in WR_REQ. Each holds, with stable address and data, until its own handshake; AW and W may complete in either cycle order.
  - Once both have completed, go to WR_RESP with BREADY=1 and wait for BVALID.
  - The next write's AWVALID/WVALID assert no earlier than the cycle after the B handshake.
- Read transaction:
  - RD_REQ holds ARVALID with ARADDR=0x000 until ARREADY.
  - RD_RESP holds RREADY=1 until RVALID; RDATA is sampled on the R handshake.
- FSM states: IDLE, WR_REQ, WR_RESP, POLL_GAP_ST, RD_REQ, RD_RESP, CONT_REQ, CONT_RESP, FIN.
- Transitions:
  - After the B handshake of the ap_start write, enter POLL_GAP_ST. Wait POLL_GAP cycles, then RD_REQ.
  - R handshake with RDATA[1]=1 (ap_done) goes to CONT_REQ and CONT_RESP, which write 0x000 = 0x0000_0010 (ap_continue), then FIN.
  - RDATA[1]=0 increments poll_cnt. If poll_cnt reaches MAX_POLLS, set status=2 and go to FIN without writing ap_continue; otherwise return to POLL_GAP_ST.
  - FIN: done=1 for exactly one cycle, busy=0 from the following cycle, and the FSM returns to IDLE. status holds until the next accepted command, which clears it to 0.
- Errors:
  - BRESP!=0 or RRESP!=0 on any transaction sets status=1. The FSM goes straight to FIN and abandons the rest of the sequence.
  - status=1 has priority over status=2 when both occur in the same cycle.
- The master never issues overlapping transactions: at most one outstanding write or read.
- ARESET mid-transaction: all outputs return to reset values on the next edge, including dropping VALIDs without a handshake. The job is lost and done is not pulsed.
- Counters saturate; they never wrap.

Decomposition:
- Package krnl_acc_ctrl_pkg:
  - register address constants: CTRL 0x000, CFG_CI 0x010, CFG_CO 0x018, IFM 0x020/0x024, WGT 0x028/0x02C, OFM 0x030/0x034;
  - CTRL bit indices: start 0, done 1, idle 2, ready 3, continue 4;
  - status encodings;
  - FSM state enum.
- Sub-module krnl_acc_axil_wr_txn: single-write engine with req/addr/data in and ack/err out, handling AW/W independence and B. Reads stay inline.

Test Plan:
- Always-ready slave model, ci=3, co=8, ifm=0x1_0000_0000, wgt=0x2000, ofm=0x3000, done after 3 polls, POLL_GAP=2 -> nine writes in the listed order with exact data (0x024 = 0x1); 3 reads with a 2-cycle gap between each; continue write 0x10; done pulse with status 0; busy low next cycle.
- AWREADY asserted 4 cycles after WREADY (and the reverse) -> AWADDR/WDATA held stable, each VALID drops the cycle after its own handshake, and exactly one B is awaited.
- BRESP=2'b10 on the CFG_CO write -> no further AW issued, done with status=1, no ap_start write observed.
- Slave never sets done, MAX_POLLS=5 -> exactly 5 reads, done with status=2, no 0x10 write.
- ARESET asserted while WVALID=1 and unhandshaken -> all VALIDs 0 the next cycle, cmd_ready=1, no done pulse; a new command then runs cleanly.
- cmd_valid toggled with new values while busy -> ignored; the register contents the slave model receives match the first descriptor only.
